byte_bus_mem_bridge: RTL
========================

// Module: byte_bus_mem_bridge
// PURPOSE
//  Memory-side partner of the CPU pin handler, on the far side of the 8-bit pins.
//  Rebuilds each 32-bit address and write word from four LSB-first byte beats, then
//  issues one request on a valid/ready memory port. Serialises the 32-bit read word
//  back as four LSB-first bytes in a fixed response window.
//  The frame is fixed-length with no stall. A late memory response is filled and flagged.
// PARAMETERS
//  FRAME_LEN   10    phases per frame (0..FRAME_LEN-1); must be >= RESP_PHASE+4
//  RESP_PHASE  6     phase at whose clock edge read byte 0 must be stable on bus_data_out
//  FILL_BYTE   8'hFF byte driven in response beats when read data is missing
// PORTS
//  clk            in   1   clock, rising edge
//  rst            in   1   asynchronous reset, active-high
//  frame_start    in   1   marks phase 0 of a frame (one-cycle pulse)
//  bus_rw         in   1   1=read frame (bridge drives data pins), 0=write frame
//  bus_addr_byte  in   8   address beat byte (CPU uo_out)
//  bus_data_in    in   8   write-data beat byte (CPU uio_out)
//  bus_data_out   out  8   read-data response byte (to CPU uio_in)
//  bus_data_oe    out  1   1 = bridge drives data pins
//  mem_req        out  1   request valid
//  mem_we         out  1   1=write, 0=read
//  mem_addr       out  32  request address
//  mem_wdata      out  32  request write data
//  mem_ready      in   1   request accepted when mem_req&mem_ready
//  mem_rvalid     in   1   read data valid (one pulse per accepted read)
//  mem_rdata      in   32  read data
//  late_err       out  1   sticky: a response window opened with read data missing
// BEHAVIOUR
//  - Reset (async, immediate) values: phase=IDLE; all outputs 0; late_err=0.
//    bus_data_out and bus_data_oe are also 0.
//  - Phases: an edge sampling frame_start=1 is phase 0. Each later edge increments the phase.
//    After FRAME_LEN-1 the phase returns to IDLE.
//  - frame_start seen mid-frame restarts the frame at phase 0. Any in-flight request is
//    abandoned: mem_req drops and a later mem_rvalid is ignored. This also sets late_err.
//  - bus_rw is sampled at phase 1 and held for the frame.
//  - Beats: at phase k (k=1..4), capture bus_addr_byte into addr[8k-1:8k-8].
//    In write frames, also capture bus_data_in into wdata[8k-1:8k-8].
//  - At the phase-4 edge: mem_req<=1, mem_we<=~rw, mem_addr/mem_wdata <= assembled words.
//    The word includes the byte captured at that same edge.
//    mem_req holds with stable payload until the mem_req&mem_ready edge, then drops.
//  - Read data: at the first edge with mem_rvalid=1, mem_rdata loads into a 32-bit
//    response register. Extra rvalid pulses in the frame are ignored.
//  - Response: bus_data_oe=1 from the phase-(RESP_PHASE-1) edge through phase RESP_PHASE+3,
//    in read frames only. Otherwise 0.
//    bus_data_out = resp byte j (j=0..3), valid at the phase RESP_PHASE+j edge.
//  - Missing data: if rvalid is not seen by the phase RESP_PHASE-1 edge, drive FILL_BYTE
//    for all four beats and set late_err. Data arriving later is discarded.
//  - Write frames: bus_data_out=0, oe=0. If the request is unaccepted by the frame end,
//    set late_err and drop mem_req.
//  - late_err clears only on rst.
// CONFIGURATION
//  BYTE_BRIDGE_STATS_EN defined:
//    - adds out ports frame_cnt[15:0] and late_cnt[15:0]. Both wrap and reset to 0.
//    - frame_cnt counts completed frames; late_cnt counts late_err events.
//  BYTE_BRIDGE_STATS_EN undefined: the ports and counters do not exist.
//  Core behaviour is identical either way.
// STRUCTURE
//  Shared package byte_bus_pkg:
//    - phase encoding typedef (IDLE, P0..)
//    - BEAT_BYTES=4, default FRAME_LEN and RESP_PHASE
//    - FILL_BYTE default
//  Sub-module byte_beat_shifter: 4x8 capture/serialise register, shared by the capture
//  path and the response path. Phase control and the memory handshake stay in the top.
// TESTING
//  - Read, 0-wait mem: addr 0x12345678, rvalid at the phase-5 edge with 0xCAFEBABE ->
//    mem_addr=0x12345678; bytes BE,BA,FE,CA at phases 6..9; oe=1 over phases 5..9.
//  - Write: addr 0x00000010, data 0xDEADBEEF, mem_ready low 2 cycles ->
//    mem_req high 3 cycles with stable payload, mem_we=1, oe=0.
//  - Late read: rvalid at phase 7 -> bytes FF,FF,FF,FF; late_err=1, stays 1 until rst.
//  - Back-to-back frames, no idle gap -> both requests issued, responses correct.
//  - frame_start at phase 3 -> restart, no request from the aborted frame;
//    the next frame decodes correctly.
//  - rst mid-frame while mem_req is high -> all outputs 0 immediately; phase IDLE.

Source files
------------

// File: rtl/byte_bus_pkg.sv
// Shared types, defaults and helpers for the byte-bus memory bridge.
package byte_bus_pkg;

  localparam int unsigned BEAT_BYTES     = 4;
  localparam int unsigned WORD_W         = BEAT_BYTES * 8;
  localparam int unsigned DEF_FRAME_LEN  = 10;
  localparam int unsigned DEF_RESP_PHASE = 6;
  localparam logic [7:0]  DEF_FILL_BYTE  = 8'hFF;
  localparam int unsigned PHASE_W        = 4;

  typedef logic [PHASE_W-1:0] ph_num_t;

  // idle=1 means no frame in progress; num is the frame phase P0..Pn otherwise.
  typedef struct packed {
    logic    idle;
    ph_num_t num;
  } phase_t;

  localparam phase_t PHASE_IDLE = '{idle: 1'b1, num: '0};
  localparam phase_t PHASE_P0   = '{idle: 1'b0, num: '0};

  function automatic logic [WORD_W-1:0] fill_word(input logic [7:0] b);
    return {BEAT_BYTES{b}};
  endfunction

  function automatic logic in_range(input ph_num_t p, input int unsigned lo,
                                    input int unsigned hi);
    return (32'(p) >= lo) && (32'(p) <= hi);
  endfunction

endpackage

// File: rtl/byte_beat_shifter.sv
// Four-byte beat register: LSB-first beats shift in at the top, or a whole word
// loads and then shifts back out from byte 0.
module byte_beat_shifter
  import byte_bus_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [WORD_W-1:0] load_word_i,
  input  logic              shift_i,
  input  logic [7:0]        shift_byte_i,
  output logic [WORD_W-1:0] word_next_o,
  output logic [7:0]        byte_o
);

  logic [WORD_W-1:0] word_q, word_d;

  always_comb begin
    word_d = word_q;
    if (load_i) begin
      word_d = load_word_i;
    end else if (shift_i) begin
      word_d = {shift_byte_i, word_q[WORD_W-1:8]};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      word_q <= '0;
    end else begin
      word_q <= word_d;
    end
  end

  assign word_next_o = word_d;
  assign byte_o      = word_q[7:0];

endmodule

// File: rtl/byte_bus_mem_bridge.sv
// Byte-bus to valid/ready memory bridge: assembles address/write words from four
// beats, issues one request, serialises read data back. BYTE_BRIDGE_STATS_EN adds counters.
module byte_bus_mem_bridge
  import byte_bus_pkg::*;
#(
  parameter int unsigned FRAME_LEN  = DEF_FRAME_LEN,
  parameter int unsigned RESP_PHASE = DEF_RESP_PHASE,
  parameter logic [7:0]  FILL_BYTE  = DEF_FILL_BYTE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              bus_rw,
  input  logic [7:0]        bus_addr_byte,
  input  logic [7:0]        bus_data_in,
  output logic [7:0]        bus_data_out,
  output logic              bus_data_oe,
  output logic              mem_req,
  output logic              mem_we,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              late_err
`ifdef BYTE_BRIDGE_STATS_EN
  ,
  output logic [15:0]       frame_cnt,
  output logic [15:0]       late_cnt
`endif
);

  localparam ph_num_t LastPh  = ph_num_t'(FRAME_LEN - 1);
  localparam ph_num_t IssuePh = ph_num_t'(BEAT_BYTES - 1);
  localparam ph_num_t DeadPh  = ph_num_t'(RESP_PHASE - 2);

  phase_t            phase_q, phase_d;
  logic              rw_q, rw_d, rd_wait_q, rd_wait_d;
  logic              req_q, req_d, we_q, we_d, late_q, late_d;
  logic [WORD_W-1:0] addr_q, addr_d, wdata_q, wdata_d;

  logic              in_frame, frame_end, restart, adv, beat, rw_cur, late_ev;
  logic              dat_load, dat_shift;
  logic [WORD_W-1:0] dat_load_word, addr_next, dat_next;
  logic [7:0]        dat_shift_in, dat_byte, unused_addr_byte;

  assign in_frame  = ~phase_q.idle;
  assign frame_end = in_frame && (phase_q.num == LastPh);
  assign restart   = frame_start && in_frame && !frame_end;
  assign adv       = in_frame && !frame_start && !frame_end;
  assign beat      = adv && (phase_q.num <= IssuePh);
  // rw is only latched at the phase-1 edge, so that edge must look at the pin itself
  assign rw_cur    = (phase_q.num == '0) ? bus_rw : rw_q;

  always_comb begin
    phase_d       = phase_q;
    rw_d          = rw_q;
    rd_wait_d     = rd_wait_q;
    req_d         = req_q;
    we_d          = we_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    dat_load      = 1'b0;
    dat_load_word = mem_rdata;
    dat_shift     = 1'b0;
    dat_shift_in  = bus_data_in;
    late_ev       = restart;

    if (frame_start) begin
      phase_d = PHASE_P0;
    end else if (frame_end) begin
      phase_d = PHASE_IDLE;
    end else if (in_frame) begin
      phase_d.num = phase_q.num + ph_num_t'(1);
    end

    if (req_q && mem_ready) req_d = 1'b0;
    if (frame_end && req_q && !mem_ready) late_ev = 1'b1;
    if (restart || frame_end) begin
      req_d     = 1'b0;
      rd_wait_d = 1'b0;
    end

    if (beat) begin
      dat_shift = ~rw_cur;
      if (phase_q.num == '0) rw_d = bus_rw;
    end

    if (adv && (phase_q.num == IssuePh)) begin
      req_d     = 1'b1;
      we_d      = ~rw_q;
      addr_d    = addr_next;
      rd_wait_d = rw_q;
      if (!rw_q) wdata_d = dat_next;
    end

    // Read data is only accepted up to the edge before the response window opens.
    if (adv && rd_wait_q) begin
      if (mem_rvalid) begin
        dat_load  = 1'b1;
        rd_wait_d = 1'b0;
      end else if (phase_q.num == DeadPh) begin
        dat_load      = 1'b1;
        dat_load_word = fill_word(FILL_BYTE);
        rd_wait_d     = 1'b0;
        late_ev       = 1'b1;
      end
    end

    if (adv && rw_q && in_range(phase_q.num, RESP_PHASE, RESP_PHASE + 2)) begin
      dat_shift    = 1'b1;
      dat_shift_in = '0;
    end

    late_d = late_q | late_ev;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q   <= PHASE_IDLE;
      rw_q      <= 1'b0;
      rd_wait_q <= 1'b0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      late_q    <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      rw_q      <= rw_d;
      rd_wait_q <= rd_wait_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      late_q    <= late_d;
    end
  end

  byte_beat_shifter u_addr_shifter (
    .clk_i        (clk),
    .rst_i        (rst),
    .load_i       (1'b0),
    .load_word_i  ('0),
    .shift_i      (beat),
    .shift_byte_i (bus_addr_byte),
    .word_next_o  (addr_next),
    .byte_o       (unused_addr_byte)
  );

  byte_beat_shifter u_data_shifter (
    .clk_i        (clk),
    .rst_i        (rst),
    .load_i       (dat_load),
    .load_word_i  (dat_load_word),
    .shift_i      (dat_shift),
    .shift_byte_i (dat_shift_in),
    .word_next_o  (dat_next),
    .byte_o       (dat_byte)
  );

  assign mem_req      = req_q;
  assign mem_we       = we_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign late_err     = late_q;
  assign bus_data_oe  = in_frame && rw_q && in_range(phase_q.num, RESP_PHASE - 1, RESP_PHASE + 3);
  assign bus_data_out = (in_frame && rw_q && in_range(phase_q.num, RESP_PHASE, RESP_PHASE + 3))
                        ? dat_byte : 8'h00;

`ifdef BYTE_BRIDGE_STATS_EN
  logic [15:0] frame_cnt_q, frame_cnt_d, late_cnt_q, late_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q + (frame_end ? 16'd1 : 16'd0);
    late_cnt_d  = late_cnt_q + (late_ev ? 16'd1 : 16'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= '0;
      late_cnt_q  <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      late_cnt_q  <= late_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign late_cnt  = late_cnt_q;
`endif

endmodule
